// File: rtl/ball_mover.sv
// Ball mover: Avalon-MM register file with shadowed host writes and a
// once-per-frame bounce update of a sprite origin, triggered by VGA_VS falling.
module ball_mover #(
    parameter int XMIN = 1,
    parameter int XMAX = 1216,
    parameter int YMIN = 1,
    parameter int YMAX = 448,
    parameter int X0   = 608,
    parameter int Y0   = 224
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic [10:0] xcoor,
    output logic [9:0]  ycoor
);

    typedef enum logic [2:0] {StIdle, StLoad, StMoveX, StMoveY, StCommit} state_e;

    localparam logic signed [12:0] XLO = 13'(XMIN);
    localparam logic signed [12:0] XHI = 13'(XMAX);
    localparam logic signed [12:0] YLO = 13'(YMIN);
    localparam logic signed [12:0] YHI = 13'(YMAX);
    localparam logic [10:0] XMIN_W = 11'(XMIN);
    localparam logic [10:0] XMAX_W = 11'(XMAX);
    localparam logic [9:0]  YMIN_W = 10'(YMIN);
    localparam logic [9:0]  YMAX_W = 10'(YMAX);

    state_e state_q, state_d;
    logic   vs_q;
    logic   tick;

    // Live state
    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic [7:0]  dx_q, dy_q;
    logic        run_q;
    logic [15:0] frames_q;

    // Host-written shadows and their pending flags
    logic [10:0] sx_q;
    logic [9:0]  sy_q;
    logic [7:0]  sdx_q, sdy_q;
    logic        srun_q;
    logic        px_q, py_q, pdx_q, pdy_q, prun_q;
    logic        pend_any;

    logic signed [12:0] nx, ny;
    logic [10:0] x_mv;
    logic [9:0]  y_mv;
    logic [7:0]  dx_mv, dy_mv;
    logic [15:0] rd_val;
    logic        unused_wd;

    assign tick      = vs_q & ~VGA_VS;
    assign pend_any  = px_q | py_q | pdx_q | pdy_q | prun_q;
    assign unused_wd = ^writedata[15:11];

    // Negation that saturates -128 to +127 so the velocity never sticks.
    function automatic logic [7:0] neg8(input logic [7:0] d);
        return (d == 8'h80) ? 8'h7F : (8'h00 - d);
    endfunction

    // State register and VGA_VS edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            vs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            vs_q    <= VGA_VS;
        end
    end

    // Next-state: ticks outside idle are dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (tick) state_d = StLoad;
            StLoad:   state_d = StMoveX;
            StMoveX:  state_d = StMoveY;
            StMoveY:  state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bounce arithmetic; out-of-range positions clamp even when stopped
    always_comb begin
        nx = {2'b00, x_q};
        if (run_q) nx = nx + {{5{dx_q[7]}}, dx_q};
        x_mv  = x_q;
        dx_mv = dx_q;
        if (nx < XLO) begin
            x_mv = XMIN_W;
            if (run_q) dx_mv = neg8(dx_q);
        end else if (nx > XHI) begin
            x_mv = XMAX_W;
            if (run_q) dx_mv = neg8(dx_q);
        end else begin
            x_mv = nx[10:0];
        end

        ny = {3'b000, y_q};
        if (run_q) ny = ny + {{5{dy_q[7]}}, dy_q};
        y_mv  = y_q;
        dy_mv = dy_q;
        if (ny < YLO) begin
            y_mv = YMIN_W;
            if (run_q) dy_mv = neg8(dy_q);
        end else if (ny > YHI) begin
            y_mv = YMAX_W;
            if (run_q) dy_mv = neg8(dy_q);
        end else begin
            y_mv = ny[9:0];
        end
    end

    // Read mux over live values
    always_comb begin
        rd_val = 16'h0000;
        case (address)
            3'd0:    rd_val = {5'b0, x_q};
            3'd1:    rd_val = {6'b0, y_q};
            3'd2:    rd_val = {{8{dx_q[7]}}, dx_q};
            3'd3:    rd_val = {{8{dy_q[7]}}, dy_q};
            3'd4:    rd_val = {14'b0, pend_any, run_q};
            3'd5:    rd_val = frames_q;
            default: rd_val = 16'h0000;
        endcase
    end

    // Datapath: frame update sequence, shadow writes, registered reads
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= 11'(X0);
            y_q      <= 10'(Y0);
            dx_q     <= 8'sd2;
            dy_q     <= 8'sd1;
            run_q    <= 1'b0;
            frames_q <= 16'h0000;
            xcoor    <= 11'(X0);
            ycoor    <= 10'(Y0);
            readdata <= 16'h0000;
            sx_q     <= '0;
            sy_q     <= '0;
            sdx_q    <= '0;
            sdy_q    <= '0;
            srun_q   <= 1'b0;
            px_q     <= 1'b0;
            py_q     <= 1'b0;
            pdx_q    <= 1'b0;
            pdy_q    <= 1'b0;
            prun_q   <= 1'b0;
        end else begin
            if (chipselect && read) readdata <= rd_val;

            unique case (state_q)
                StLoad: begin
                    if (px_q)   x_q   <= sx_q;
                    if (py_q)   y_q   <= sy_q;
                    if (pdx_q)  dx_q  <= sdx_q;
                    if (pdy_q)  dy_q  <= sdy_q;
                    if (prun_q) run_q <= srun_q;
                    px_q   <= 1'b0;
                    py_q   <= 1'b0;
                    pdx_q  <= 1'b0;
                    pdy_q  <= 1'b0;
                    prun_q <= 1'b0;
                end
                StMoveX: begin
                    x_q  <= x_mv;
                    dx_q <= dx_mv;
                end
                StMoveY: begin
                    y_q  <= y_mv;
                    dy_q <= dy_mv;
                end
                StCommit: begin
                    xcoor    <= x_q;
                    ycoor    <= y_q;
                    frames_q <= frames_q + 16'd1;
                end
                default: ;
            endcase

            // Placed after the LOAD clear so a write in LOAD stays pending
            if (chipselect && write) begin
                case (address)
                    3'd0: begin sx_q   <= writedata[10:0]; px_q   <= 1'b1; end
                    3'd1: begin sy_q   <= writedata[9:0];  py_q   <= 1'b1; end
                    3'd2: begin sdx_q  <= writedata[7:0];  pdx_q  <= 1'b1; end
                    3'd3: begin sdy_q  <= writedata[7:0];  pdy_q  <= 1'b1; end
                    3'd4: begin srun_q <= writedata[0];    prun_q <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_ball_mover;

    localparam int XMIN = 1, XMAX = 1216, YMIN = 1, YMAX = 448, X0 = 608, Y0 = 224;
    localparam int OP_WR = 0, OP_RD = 1, OP_TK = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        VGA_VS = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  address = '0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic [10:0] xcoor;
    logic [9:0]  ycoor;

    int tests = 0;
    int fails = 0;

    ball_mover #(
        .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX), .X0(X0), .Y0(Y0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .VGA_VS(VGA_VS),
        .chipselect(chipselect),
        .write(write),
        .read(read),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .xcoor(xcoor),
        .ycoor(ycoor)
    );

    always #10 clk = ~clk;

    // Behavioural model state
    int m_x, m_y, m_dx, m_dy, m_run, m_fr, m_xc, m_yc;
    int s_x, s_y, s_dx, s_dy, s_run;
    bit p_x, p_y, p_dx, p_dy, p_run;

    typedef struct {
        int op;
        int addr;
        int data;
        int e1;
        int e2;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input int op, input int a, input int d, input int e1,
                                input int e2);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.e1 = e1; v.e2 = e2;
        tbl.push_back(v);
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic void model_reset();
        m_x = X0; m_y = Y0; m_dx = 2; m_dy = 1; m_run = 0; m_fr = 0;
        m_xc = X0; m_yc = Y0;
        s_x = 0; s_y = 0; s_dx = 0; s_dy = 0; s_run = 0;
        p_x = 0; p_y = 0; p_dx = 0; p_dy = 0; p_run = 0;
    endfunction

    function automatic int sbyte(input int d);
        int b;
        b = d & 255;
        return (b > 127) ? b - 256 : b;
    endfunction

    function automatic void model_write(input int a, input int d);
        case (a)
            0: begin s_x = d & 16'h7FF; p_x = 1; end
            1: begin s_y = d & 16'h3FF; p_y = 1; end
            2: begin s_dx = sbyte(d); p_dx = 1; end
            3: begin s_dy = sbyte(d); p_dy = 1; end
            4: begin s_run = d & 1; p_run = 1; end
            default: ;
        endcase
    endfunction

    function automatic int negsat(input int d);
        return (d == -128) ? 127 : -d;
    endfunction

    task automatic move(inout int p, inout int d, input int run, input int lo, input int hi);
        int n;
        n = run ? p + d : p;
        if (n < lo) begin
            p = lo;
            if (run != 0) d = negsat(d);
        end else if (n > hi) begin
            p = hi;
            if (run != 0) d = negsat(d);
        end else begin
            p = n;
        end
    endtask

    task automatic model_frame();
        if (p_x)   m_x = s_x;
        if (p_y)   m_y = s_y;
        if (p_dx)  m_dx = s_dx;
        if (p_dy)  m_dy = s_dy;
        if (p_run) m_run = s_run;
        p_x = 0; p_y = 0; p_dx = 0; p_dy = 0; p_run = 0;
        move(m_x, m_dx, m_run, XMIN, XMAX);
        move(m_y, m_dy, m_run, YMIN, YMAX);
        m_xc = m_x; m_yc = m_y;
        m_fr = (m_fr + 1) % 65536;
    endtask

    function automatic int exp_read(input int a);
        case (a)
            0: return m_x;
            1: return m_y;
            2: return m_dx & 16'hFFFF;
            3: return m_dy & 16'hFFFF;
            4: return ((p_x | p_y | p_dx | p_dy | p_run) ? 2 : 0) + m_run;
            5: return m_fr;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        chipselect = 1'b1; write = 1'b1; address = 3'(a); writedata = 16'(d);
        step();
        chipselect = 1'b0; write = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_read(input int a, output int v);
        chipselect = 1'b1; read = 1'b1; address = 3'(a);
        step();
        v = int'(readdata);
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Outputs must hold for three cycles after the tick edge and update on the fourth.
    task automatic do_tick();
        int oxc, oyc;
        oxc = m_xc; oyc = m_yc;
        VGA_VS = 1'b0;
        step();
        VGA_VS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold xcoor c%0d", i + 1), int'(xcoor), oxc);
            check($sformatf("hold ycoor c%0d", i + 1), int'(ycoor), oyc);
        end
        step();
        model_frame();
        check("commit xcoor", int'(xcoor), m_xc);
        check("commit ycoor", int'(ycoor), m_yc);
    endtask

    initial begin
        int v, a, d, r;

        // Directed table: values derived by hand from the bounce rules
        add(OP_RD, 0, 0, 608, 0);
        add(OP_RD, 1, 0, 224, 0);
        add(OP_RD, 2, 0, 2, 0);
        add(OP_RD, 3, 0, 1, 0);
        add(OP_RD, 4, 0, 0, 0);
        add(OP_RD, 5, 0, 0, 0);
        add(OP_TK, 0, 0, 608, 224);
        add(OP_TK, 0, 0, 608, 224);
        add(OP_TK, 0, 0, 608, 224);
        add(OP_RD, 5, 0, 3, 0);
        add(OP_WR, 4, 1, 0, 0);
        add(OP_RD, 4, 0, 2, 0);          // run still 0 live, pending set
        add(OP_TK, 0, 0, 610, 225);
        add(OP_RD, 4, 0, 1, 0);
        add(OP_RD, 5, 0, 4, 0);
        add(OP_WR, 0, 1215, 0, 0);
        add(OP_WR, 2, 4, 0, 0);
        add(OP_TK, 0, 0, 1216, 226);
        add(OP_RD, 2, 0, 16'hFFFC, 0);
        add(OP_TK, 0, 0, 1212, 227);
        add(OP_WR, 1, 2, 0, 0);
        add(OP_WR, 3, 16'h00FB, 0, 0);
        add(OP_TK, 0, 0, 1208, 1);
        add(OP_RD, 3, 0, 5, 0);
        add(OP_TK, 0, 0, 1204, 6);
        add(OP_WR, 6, 16'hFFFF, 0, 0);
        add(OP_RD, 6, 0, 0, 0);
        add(OP_RD, 7, 0, 0, 0);
        add(OP_WR, 5, 16'h1234, 0, 0);
        add(OP_RD, 5, 0, 8, 0);
        add(OP_WR, 0, 50, 0, 0);
        add(OP_WR, 2, 16'h0080, 0, 0);   // -128 bounces off the left wall
        add(OP_TK, 0, 0, 1, 11);
        add(OP_RD, 2, 0, 127, 0);

        model_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset xcoor", int'(xcoor), 608);
        check("reset ycoor", int'(ycoor), 224);
        check("reset readdata", int'(readdata), 0);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR: do_write(tbl[i].addr, tbl[i].data);
                OP_RD: begin
                    do_read(tbl[i].addr, v);
                    check($sformatf("vec%0d read a%0d", i, tbl[i].addr), v, tbl[i].e1);
                end
                default: begin
                    do_tick();
                    check($sformatf("vec%0d xcoor", i), int'(xcoor), tbl[i].e1);
                    check($sformatf("vec%0d ycoor", i), int'(ycoor), tbl[i].e2);
                end
            endcase
        end

        // Write X during LOAD: this frame uses old x, the write waits a frame
        VGA_VS = 1'b0;
        step();
        VGA_VS = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 16'd100;
        step();
        chipselect = 1'b0; write = 1'b0;
        model_frame();
        model_write(0, 100);
        step();
        step();
        step();
        check("load-write xcoor old", int'(xcoor), 128);
        check("load-write ycoor", int'(ycoor), 16);
        do_read(4, v);
        check("load-write pending", v, 3);
        do_tick();
        check("load-write xcoor new", int'(xcoor), 227);
        do_read(4, v);
        check("load-write pending cleared", v, 1);

        // Reset mid-update (in MOVE_Y) with a pending write outstanding
        VGA_VS = 1'b0;
        step();
        VGA_VS = 1'b1;
        step();
        chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 16'd300;
        step();
        chipselect = 1'b0; write = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check("midreset xcoor", int'(xcoor), 608);
        check("midreset ycoor", int'(ycoor), 224);
        do_read(4, v);
        check("midreset ctrl", v, 0);
        do_read(1, v);
        check("midreset y", v, 224);
        do_read(5, v);
        check("midreset frames", v, 0);
        do_tick();
        check("post-reset tick xcoor", int'(xcoor), 608);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                a = $urandom_range(0, 7);
                case (a)
                    0: d = $urandom_range(0, 1400);
                    1: d = $urandom_range(0, 600);
                    4: d = ($urandom_range(0, 9) != 0) ? 1 : 0;
                    default: d = $urandom_range(0, 65535);
                endcase
                do_write(a, d);
            end else if (r <= 6) begin
                a = $urandom_range(0, 7);
                do_read(a, v);
                check($sformatf("rand read a%0d", a), v, exp_read(a));
            end else begin
                do_tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
